rf_wb_ctrl: RTL and testbench
=============================

# rf_wb_ctrl

Write-back controller for the 32x32 integer register file. It owns the file's single write port and sequences a post-reset clear of x1..x31. It arbitrates that port between the single-cycle ALU write-back, which never stalls, and the long-latency LSU/MDU write-back, which uses a valid/ready handshake. It also keeps a pending-write scoreboard that stalls issue on RAW/WAW hazards against outstanding long-latency destinations. It sits between the core pipeline's write-back stage and the register file's we/A3/WD inputs.

## Interface
- XLEN, 32, data width
- NREG, 32, register count; index width AW = $clog2(NREG) = 5
- STARVE, 4, consecutive blocked LSU cycles before alu_hold asserts (1..15)
- clk  in  1  core clock; all state on rising edge
- res  in  1  asynchronous active-low reset
- alu_we / alu_rd / alu_wd  in  1 / AW / XLEN  ALU write-back; always accepted
- lsu_valid / lsu_rd / lsu_wd  in  1 / AW / XLEN  long-latency write-back request
- lsu_ready  out  1  combinational grant to LSU
- iss_mark / iss_rd  in  1 / AW  issue stage marks rd pending for a long-latency op
- chk_rs1 / chk_rs2 / chk_rd  in  AW each  operands of the instruction in issue
- stall  out  1  combinational issue stall
- alu_hold  out  1  registered request to pipeline: stop producing ALU write-backs
- rf_we / rf_a3 / rf_wd  out  1 / AW / XLEN  registered write port to register file
- init_done  out  1  register file cleared, controller in RUN

## Operation
- FSM: CLR -> FIN -> RUN. Reset forces CLR with clr_idx=1.
- CLR: each edge drives rf_we<=1, rf_a3<=clr_idx, rf_wd<=0, then clr_idx++. After the edge that issues index 31, go to FIN.
- FIN: the edge drives rf_we<=0 and goes to RUN.
- In CLR and FIN: lsu_ready=0, stall=1, and alu_we is ignored.
- RUN grant: lsu_ready = !(alu_we && alu_rd!=0). ALU has fixed priority.
- RUN output on each edge:
  - ALU write with alu_rd!=0: rf_we<=1, rf_a3<=alu_rd, rf_wd<=alu_wd.
  - Otherwise, LSU handshake (lsu_valid&&lsu_ready): drive the LSU fields.
  - Otherwise: rf_we<=0, with rf_a3 and rf_wd held.
  - Writes to x0 are never forwarded; lsu_rd==0 still completes the handshake.
- Scoreboard pending[NREG-1:0]:
  - iss_mark with iss_rd!=0 sets pending[iss_rd].
  - A bit is cleared on the edge its LSU write lands, one edge after the handshake.
  - The clear is driven by a registered clr_rd/clr_v pair.
  - Set and clear of the same index on the same edge: set wins.
  - pending[0] is always 0.
- stall = !init_done | pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd].
- Starvation counter blk_cnt (4 bit):
  - Increments each RUN cycle with lsu_valid && !lsu_ready, saturating at STARVE.
  - Clears on a handshake.
  - alu_hold<=1 when blk_cnt reaches STARVE; alu_hold<=0 on the edge following a handshake.
- Pipeline contract:
  - alu_we may continue while alu_hold is high (in-flight ops) and still wins.
  - The pipeline guarantees drain.

## Timing
- Reset values:
  - rf_we=0, rf_a3=0, rf_wd=0, alu_hold=0, init_done=0.
  - lsu_ready=0, stall=1.
  - pending=0, blk_cnt=0, state=CLR.
- Reset is asynchronous in any state, including mid-clear or with pending bits set. It restarts the full clear; all pending bits and the LSU handshake are dropped.
- Clear sequence:
  - rf_we is high for 31 cycles (x1..x31), starting after the 1st edge following reset release.
  - init_done rises after the 32nd edge, when x31 is written.
- Write latency: an accept in cycle t gives rf_we during t+1, and the file is updated at the end of t+1.
- The scoreboard bit clears on that same edge, so a dependent instruction unstalls in t+2 and reads the new value.
- No bypass exists; ALU RAW forwarding is the pipeline's job.
- lsu_valid/lsu_rd/lsu_wd must stay stable while lsu_ready=0.

## Structure
- The shared core package holds:
  - XLEN, NREG, AW.
  - The FSM state enum {CLR, FIN, RUN}.
  - The write-port struct {we, a3, wd}, reused by the pipeline.
- One sub-module: rf_scoreboard. It contains pending bits, set/clear priority and the 3-port combinational lookup.
- Arbitration, FSM and starvation counter live in rf_wb_ctrl.

## Test plan
- Reset release:
  - rf_we high for exactly 31 cycles with rf_a3 = 1..31 and rf_wd = 0.
  - init_done rises on the 32nd edge.
  - stall stays 1 until then, and lsu_ready stays 0.
- Contention:
  - alu_we=1, alu_rd=5, alu_wd=0xAAAA_0001, together with lsu_valid=1, lsu_rd=7, lsu_wd=0x1234.
  - Expect lsu_ready=0 and rf writes x5=0xAAAA_0001.
  - The next cycle with alu_we=0 grants the LSU, giving rf_a3=7, rf_wd=0x1234.
- Scoreboard:
  - iss_mark on rd=9; chk_rs1=9 gives stall=1.
  - LSU handshake for rd=9 at t; stall drops in t+2.
  - iss_mark rd=9 on the same edge as the clear leaves stall=1.
- x0:
  - alu_we with alu_rd=0 gives rf_we=0 and lsu_ready=1.
  - iss_mark with rd=0 never stalls.
- Starvation:
  - lsu_valid held with alu_we=1 for 4 cycles: alu_hold=1 after the 4th edge.
  - Drop alu_we: handshake occurs and alu_hold returns to 0 the next edge.
- Mid-operation reset:
  - Assert res low at clear index 12 with pending[3] set.
  - All outputs return to reset values immediately, and the clear restarts at x1.

Source files
------------

// File: rtl/rf_wb_ctrl_pkg.sv
// Shared core definitions for the register-file write-back path:
// widths, controller FSM encoding and the write-port bundle.
package rf_wb_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef enum logic [1:0] {
        CLR,
        FIN,
        RUN
    } state_t;

    // Register-file write port, also used by the pipeline's own write-back stage.
    typedef struct packed {
        logic            we;
        logic [AW-1:0]   a3;
        logic [XLEN-1:0] wd;
    } wport_t;

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Write-back request bus: single-cycle ALU result plus the long-latency
// LSU/MDU result with its valid/ready handshake.
interface rf_wb_if
    import rf_wb_ctrl_pkg::*;
();

    logic            alu_we;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_wd;
    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_wd;
    logic            lsu_ready;

    modport master (
        output alu_we, alu_rd, alu_wd,
        output lsu_valid, lsu_rd, lsu_wd,
        input  lsu_ready
    );

    modport slave (
        input  alu_we, alu_rd, alu_wd,
        input  lsu_valid, lsu_rd, lsu_wd,
        output lsu_ready
    );

endinterface

// File: rtl/rf_wb_ctrl_scoreboard.sv
// Pending-write scoreboard for long-latency destinations, with a
// three-operand combinational hazard lookup for the issue stage.
module rf_scoreboard
    import rf_wb_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          res,
    input  logic          set_v,
    input  logic [AW-1:0] set_rd,
    input  logic          clr_v,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] chk_rs1,
    input  logic [AW-1:0] chk_rs2,
    input  logic [AW-1:0] chk_rd,
    output logic          hit
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // NOTE: every always_comb output is given a full default first so no path can infer a latch.
    always_comb begin
        pending_d = pending_q;
        if (clr_v) pending_d[clr_rd] = 1'b0;
        // Applied after the clear so a re-issue on the landing edge keeps the bit.
        if (set_v) pending_d[set_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // NOTE: state is updated with non-blocking assignments only; blocking ones would race other flops.
    always_ff @(posedge clk or negedge res) begin
        if (!res) pending_q <= '0;
        else      pending_q <= pending_d;
    end

    assign hit = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: post-reset clear of x1..x31, ALU/LSU
// arbitration of the single write port, LSU starvation hold and issue stall.
module rf_wb_ctrl
    import rf_wb_ctrl_pkg::*;
#(
    parameter int STARVE = 4
) (
    input  logic            clk,
    input  logic            res,
    rf_wb_if.slave          bus,
    input  logic            iss_mark,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    input  logic [AW-1:0]   chk_rd,
    output logic            stall,
    output logic            alu_hold,
    output logic            rf_we,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd,
    output logic            init_done
);

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    wport_t        wp_q, wp_d;
    logic [3:0]    blk_q, blk_d;
    logic          hold_q;
    logic          clr_v_q;
    logic [AW-1:0] clr_rd_q;
    logic          alu_wr;
    logic          hs;
    logic          hit;

    assign alu_wr = bus.alu_we && (bus.alu_rd != '0);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= CLR;
            clr_idx_q <= AW'(1);
            wp_q      <= '0;
            blk_q     <= '0;
            hold_q    <= 1'b0;
            clr_v_q   <= 1'b0;
            clr_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wp_q      <= wp_d;
            blk_q     <= blk_d;
            hold_q    <= (blk_d == 4'(STARVE));
            // The scoreboard bit drops on the edge the LSU data lands in the file.
            clr_v_q   <= hs && (bus.lsu_rd != '0);
            clr_rd_q  <= bus.lsu_rd;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREG - 1)) state_d = FIN;
            end
            FIN:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        bus.lsu_ready = 1'b0;
        hs            = 1'b0;
        wp_d          = wp_q;
        wp_d.we       = 1'b0;
        blk_d         = '0;
        case (state_q)
            CLR: wp_d = '{we: 1'b1, a3: clr_idx_q, wd: '0};
            RUN: begin
                bus.lsu_ready = !alu_wr;
                hs            = bus.lsu_valid && !alu_wr;
                if (alu_wr)
                    wp_d = '{we: 1'b1, a3: bus.alu_rd, wd: bus.alu_wd};
                else if (hs && (bus.lsu_rd != '0))
                    wp_d = '{we: 1'b1, a3: bus.lsu_rd, wd: bus.lsu_wd};
                blk_d = blk_q;
                if (hs)
                    blk_d = '0;
                else if (bus.lsu_valid && (blk_q != 4'(STARVE)))
                    blk_d = blk_q + 4'd1;
            end
            default: ;
        endcase
    end

    rf_scoreboard u_sb (
        .clk     (clk),
        .res     (res),
        .set_v   (iss_mark),
        .set_rd  (iss_rd),
        .clr_v   (clr_v_q),
        .clr_rd  (clr_rd_q),
        .chk_rs1 (chk_rs1),
        .chk_rs2 (chk_rs2),
        .chk_rd  (chk_rd),
        .hit     (hit)
    );

    assign init_done = (state_q == RUN);
    assign stall     = !init_done | hit;
    assign alu_hold  = hold_q;
    assign rf_we     = wp_q.we;
    assign rf_a3     = wp_q.a3;
    assign rf_wd     = wp_q.wd;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_rf_wb_ctrl;
    import rf_wb_ctrl_pkg::*;

    localparam int STARVE = 4;

    logic            clk = 1'b0;
    logic            res;
    logic            iss_mark;
    logic [AW-1:0]   iss_rd, chk_rs1, chk_rs2, chk_rd;
    logic            stall, alu_hold, rf_we, init_done;
    logic [AW-1:0]   rf_a3;
    logic [XLEN-1:0] rf_wd;

    rf_wb_if bus ();

    rf_wb_ctrl #(.STARVE(STARVE)) dut (
        .clk       (clk),
        .res       (res),
        .bus       (bus),
        .iss_mark  (iss_mark),
        .iss_rd    (iss_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rd    (chk_rd),
        .stall     (stall),
        .alu_hold  (alu_hold),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            alu_we;
        logic [AW-1:0]   alu_rd;
        logic [XLEN-1:0] alu_wd;
        logic            lsu_valid;
        logic [AW-1:0]   lsu_rd;
        logic [XLEN-1:0] lsu_wd;
        logic            iss_mark;
        logic [AW-1:0]   iss_rd;
        logic [AW-1:0]   chk_rs1;
        logic            exp_ready;
        logic            exp_stall;
        logic            exp_we;
        logic [AW-1:0]   exp_a3;
        logic [XLEN-1:0] exp_wd;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model: counts clear edges, tracks pending destinations as a
    // bit set, and a queue of destinations whose data lands on the next edge.
    int              m_edges;
    bit              m_done;
    bit [NREG-1:0]   m_pend;
    bit              m_we;
    bit [AW-1:0]     m_a3;
    bit [XLEN-1:0]   m_wd;
    int              m_blk;
    bit              m_hold;
    int              land_q[$];
    logic [XLEN-1:0] exp_rf[NREG];
    logic [XLEN-1:0] dut_rf[NREG];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic aw, logic [AW-1:0] ard, logic [XLEN-1:0] awd,
                                logic lv, logic [AW-1:0] lrd, logic [XLEN-1:0] lwd,
                                logic im, logic [AW-1:0] ird, logic [AW-1:0] c1,
                                logic er, logic es, logic ewe, logic [AW-1:0] ea3,
                                logic [XLEN-1:0] ewd);
        vec_t v;
        v.alu_we = aw;   v.alu_rd = ard;  v.alu_wd = awd;
        v.lsu_valid = lv; v.lsu_rd = lrd; v.lsu_wd = lwd;
        v.iss_mark = im; v.iss_rd = ird;  v.chk_rs1 = c1;
        v.exp_ready = er; v.exp_stall = es;
        v.exp_we = ewe;  v.exp_a3 = ea3;  v.exp_wd = ewd;
        return v;
    endfunction

    function automatic bit model_ready();
        return m_done && !(bus.alu_we && (bus.alu_rd != '0));
    endfunction

    task automatic model_reset();
        m_edges = 0; m_done = 0; m_pend = '0;
        m_we = 0; m_a3 = '0; m_wd = '0;
        m_blk = 0; m_hold = 0;
        land_q.delete();
    endtask

    task automatic idle();
        bus.alu_we = 1'b0;    bus.alu_rd = '0; bus.alu_wd = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_wd = '0;
        iss_mark = 1'b0; iss_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    endtask

    task automatic check_outputs();
        bit er, es;
        er = model_ready();
        es = !m_done || m_pend[chk_rs1] || m_pend[chk_rs2] || m_pend[chk_rd];
        check("rf_we",     32'(rf_we),         32'(m_we));
        check("rf_a3",     32'(rf_a3),         32'(m_a3));
        check("rf_wd",     rf_wd,              m_wd);
        check("alu_hold",  32'(alu_hold),      32'(m_hold));
        check("init_done", 32'(init_done),     32'(m_done));
        check("lsu_ready", 32'(bus.lsu_ready), 32'(er));
        check("stall",     32'(stall),         32'(es));
        if (rf_we) dut_rf[rf_a3] = rf_wd;
        if (m_we)  exp_rf[m_a3]  = m_wd;
    endtask

    task automatic model_edge();
        bit rdy, hs;
        rdy = model_ready();
        hs  = rdy && bus.lsu_valid;
        if (land_q.size() > 0) m_pend[land_q.pop_front()] = 1'b0;
        if (iss_mark && (iss_rd != '0)) m_pend[iss_rd] = 1'b1;
        if (hs && (bus.lsu_rd != '0)) land_q.push_back(int'(bus.lsu_rd));
        if (!m_done) begin
            m_edges++;
            if (m_edges < NREG) begin
                m_we = 1; m_a3 = AW'(m_edges); m_wd = '0;
            end else begin
                m_we = 0; m_done = 1;
            end
        end else if (bus.alu_we && (bus.alu_rd != '0)) begin
            m_we = 1; m_a3 = bus.alu_rd; m_wd = bus.alu_wd;
        end else if (hs && (bus.lsu_rd != '0)) begin
            m_we = 1; m_a3 = bus.lsu_rd; m_wd = bus.lsu_wd;
        end else begin
            m_we = 0;
        end
        if (hs) m_blk = 0;
        else if (m_done && bus.lsu_valid && !rdy && (m_blk < STARVE)) m_blk++;
        m_hold = (m_blk == STARVE);
    endtask

    // Inputs are driven 1ns after the rising edge; outputs are checked on the falling edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_outputs();
        @(posedge clk); #1;
        res = 1'b1;
    endtask

    task automatic run_clear();
        int we_cnt;
        we_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            bus.alu_we = 1'($urandom_range(0, 1));
            bus.alu_rd = AW'($urandom);
            bus.alu_wd = $urandom;
            cycle();
            if (rf_we) we_cnt++;
            check("clear_done_edge", 32'(init_done), 32'(i == 31));
        end
        check("clear_we_cycles", 32'(we_cnt), 32'd31);
        idle();
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            exp_rf[i] = '0;
            dut_rf[i] = '0;
        end
        idle();
        do_reset();
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_ready", 32'(bus.lsu_ready), 32'd0);
        run_clear();

        vecs.push_back(mk(1'b1, 5'd5, 32'hAAAA_0001, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hAAAA_0001));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h1234));
        vecs.push_back(mk(1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234));
        vecs.push_back(mk(1'b1, 5'd0, 32'h55,        1'b1, 5'd0, 32'h77,   1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234));
        vecs.push_back(mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd7, 32'h1234));
        foreach (vecs[i]) begin
            bus.alu_we = vecs[i].alu_we;       bus.alu_rd = vecs[i].alu_rd; bus.alu_wd = vecs[i].alu_wd;
            bus.lsu_valid = vecs[i].lsu_valid; bus.lsu_rd = vecs[i].lsu_rd; bus.lsu_wd = vecs[i].lsu_wd;
            iss_mark = vecs[i].iss_mark; iss_rd = vecs[i].iss_rd; chk_rs1 = vecs[i].chk_rs1;
            #2;
            check($sformatf("vec%0d_ready", i), 32'(bus.lsu_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_stall", i), 32'(stall),         32'(vecs[i].exp_stall));
            cycle();
            check($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_a3", i), 32'(rf_a3), 32'(vecs[i].exp_a3));
            check($sformatf("vec%0d_wd", i), rf_wd,      vecs[i].exp_wd);
        end

        // x9 is pending: handshake at t, stall still high in t+1, clear in t+2.
        idle(); chk_rs1 = 5'd9;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_wd = 32'h0909_0909;
        #2; check("sb_stall_t", 32'(stall), 32'd1);
        cycle();
        bus.lsu_valid = 1'b0;
        #2; check("sb_stall_t1", 32'(stall), 32'd1);
        check("sb_land_a3", 32'(rf_a3), 32'd9);
        cycle();
        #2; check("sb_stall_t2", 32'(stall), 32'd0);
        // Re-mark x9 on the very edge its previous write lands.
        iss_mark = 1'b1; iss_rd = 5'd9;
        cycle();
        iss_mark = 1'b0;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_wd = 32'h0000_0099;
        cycle();
        bus.lsu_valid = 1'b0; iss_mark = 1'b1; iss_rd = 5'd9;
        cycle();
        iss_mark = 1'b0;
        #2; check("sb_set_wins", 32'(stall), 32'd1);
        bus.lsu_valid = 1'b1; bus.lsu_wd = 32'h0000_0999;
        cycle();
        bus.lsu_valid = 1'b0;
        cycle();
        #2; check("sb_cleared", 32'(stall), 32'd0);

        // Starvation: four blocked cycles raise alu_hold; the handshake drops it.
        idle();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_wd = 32'hBEEF;
        for (int k = 1; k <= 4; k++) begin
            bus.alu_we = 1'b1; bus.alu_rd = 5'd12; bus.alu_wd = 32'(k);
            cycle();
            check($sformatf("starve_hold%0d", k), 32'(alu_hold), 32'(k == 4));
        end
        bus.alu_we = 1'b0;
        #2; check("starve_ready", 32'(bus.lsu_ready), 32'd1);
        cycle();
        check("starve_release", 32'(alu_hold), 32'd0);
        check("starve_a3", 32'(rf_a3), 32'd11);
        idle();
        cycle();

        // Randomized traffic against the model, LSU request held stable until granted.
        for (int n = 0; n < 800; n++) begin
            bit hs;
            if (!bus.lsu_valid && ($urandom_range(0, 2) == 0)) begin
                bus.lsu_valid = 1'b1;
                bus.lsu_rd = AW'($urandom);
                bus.lsu_wd = $urandom;
            end
            bus.alu_we = m_hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            bus.alu_rd = AW'($urandom);
            bus.alu_wd = $urandom;
            iss_mark = ($urandom_range(0, 3) == 0);
            iss_rd   = AW'($urandom);
            chk_rs1  = AW'($urandom);
            chk_rs2  = AW'($urandom);
            chk_rd   = AW'($urandom);
            hs = bus.lsu_valid && model_ready();
            cycle();
            if (hs) bus.lsu_valid = 1'b0;
        end
        idle();
        cycle();
        cycle();
        for (int i = 0; i < NREG; i++) check($sformatf("rf_x%0d", i), dut_rf[i], exp_rf[i]);

        // Reset mid-clear with x3 pending: everything drops at once, clear restarts at x1.
        do_reset();
        iss_mark = 1'b1; iss_rd = 5'd3;
        cycle();
        iss_mark = 1'b0;
        repeat (11) cycle();
        check("mid_idx12", 32'(rf_a3), 32'd12);
        res = 1'b0;
        #1;
        check("mid_rst_we",   32'(rf_we),         32'd0);
        check("mid_rst_a3",   32'(rf_a3),         32'd0);
        check("mid_rst_stall", 32'(stall),        32'd1);
        check("mid_rst_ready", 32'(bus.lsu_ready), 32'd0);
        check("mid_rst_done", 32'(init_done),     32'd0);
        do_reset();
        cycle();
        check("mid_restart_a3", 32'(rf_a3), 32'd1);
        repeat (31) cycle();
        chk_rs1 = 5'd3;
        #2; check("mid_pend_dropped", 32'(stall), 32'd0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
